rom_stream_reader: RTL and testbench



---
 rtl/rom_stream_pkg.sv | 6 +
 rtl/rom_stream_outreg.sv | 31 +++
 rtl/rom_stream_reader.sv | 77 +++++++
 tb/tb_rom_stream_reader.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rom_stream_pkg.sv
// rom_stream_pkg: shared state encoding and default widths for rom_stream_reader.
package rom_stream_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int ROM_DATA_W = 8;
    localparam int ROM_ADDR_W = 3;
endpackage

// File: rtl/rom_stream_outreg.sv
// rom_stream_outreg: load-gated stream output register; a bare accept empties it.
module rom_stream_outreg
    import rom_stream_pkg::*;
#(
    parameter int DATA_WIDTH = ROM_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  accept,
    input  logic [DATA_WIDTH-1:0] word,
    input  logic                  word_last,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  last
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (load) begin
            data  <= word;
            valid <= 1'b1;
            last  <= word_last;
        end else if (accept) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end
endmodule

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks an async ROM over an inclusive, wrapping address range and streams the words.
// Optional ROM_STREAM_LOOP_EN adds a loop input that restarts the range instead of finishing.
module rom_stream_reader
    import rom_stream_pkg::*;
#(
    parameter int DATA_WIDTH = ROM_DATA_W,
    parameter int ADDR_WIDTH = ROM_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
`ifdef ROM_STREAM_LOOP_EN
    input  logic                  loop,
`endif
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);
    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_reg, last_reg, start_reg;
    logic                  loop_en, at_last, load, accept;
`ifdef ROM_STREAM_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif
    assign at_last  = addr_reg == last_reg;
    assign load     = !out_valid || out_ready;
    assign accept   = out_valid && out_ready;
    assign rom_addr = addr_reg;
    assign busy     = state != IDLE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_reg  <= '0;
            last_reg  <= '0;
            start_reg <= '0;
            done      <= 1'b0;
        end else begin
            // a pass completes whenever its final word is taken, in RUN (looping) or DRAIN
            done <= accept && out_last;
            case (state)
                IDLE: if (start) begin
                    addr_reg  <= start_addr;
                    last_reg  <= last_addr;
                    start_reg <= start_addr;
                    state     <= RUN;
                end
                RUN: if (load) begin
                    if (!at_last) addr_reg <= addr_reg + 1'b1;
                    else if (loop_en) addr_reg <= start_reg;
                    else state <= DRAIN;
                end
                DRAIN: if (accept) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    rom_stream_outreg #(.DATA_WIDTH(DATA_WIDTH)) u_outreg (
        .clk       (clk),
        .reset     (reset),
        .load      (state == RUN && load),
        .accept    (accept),
        .word      (rom_q),
        .word_last (at_last),
        .data      (out_data),
        .valid     (out_valid),
        .last      (out_last)
    );
endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: directed checks of rom_stream_reader against an 8x8 async bench ROM.
module tb_rom_stream_reader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] start_addr = '0;
    logic [2:0] last_addr = '0;
    logic [2:0] rom_addr;
    logic [7:0] rom_q;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic       busy;
    logic       done;
`ifdef ROM_STREAM_LOOP_EN
    logic       loop = 1'b0;
`endif
    int passed = 0;
    int total = 0;
    logic [7:0] rom [8] = '{8'hAA, 8'hF0, 8'h0F, 8'hCC, 8'hE7, 8'h18, 8'hB7, 8'hED};
    assign rom_q = rom[rom_addr];
    always #5 clk = ~clk;
    rom_stream_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .last_addr  (last_addr),
`ifdef ROM_STREAM_LOOP_EN
        .loop       (loop),
`endif
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );
    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (rom_addr !== 3'd0) $display("FAIL reset rom_addr got %0h want 0", rom_addr); else passed++;
        total++; if (out_data !== 8'h00) $display("FAIL reset out_data got %0h want 0", out_data); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset out_valid got %0b want 0", out_valid); else passed++;
        total++; if (out_last !== 1'b0) $display("FAIL reset out_last got %0b want 0", out_last); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset busy got %0b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset done got %0b want 0", done); else passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask
    // exp holds the expected words packed MSB-first; ends on the negedge where done should be high
    task automatic test_pass(input string name, input logic [2:0] sa, input logic [2:0] la, input int n, input logic [63:0] exp);
        start_addr = sa;
        last_addr = la;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0 || rom_addr !== sa)
            $display("FAIL %s first-cycle got busy=%0b valid=%0b done=%0b addr=%0h want 1 0 0 %0h", name, busy, out_valid, done, rom_addr, sa);
        else passed++;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[63-8*i -: 8] || out_last !== (i == n - 1) || done !== 1'b0)
                $display("FAIL %s word%0d got valid=%0b data=%0h last=%0b done=%0b want 1 %0h %0b 0", name, i, out_valid, out_data, out_last, done, exp[63-8*i -: 8], i == n - 1);
            else passed++;
            @(negedge clk);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL %s end got done=%0b busy=%0b valid=%0b want 1 0 0", name, done, busy, out_valid);
        else passed++;
    endtask
    task automatic test_backpressure();
        logic [63:0] exp = 64'hAAF00FCCE718B7ED;
        logic [3:0] pattern = 4'b1001;
        int idx = 0;
        int c = 0;
        start_addr = 3'd0;
        last_addr = 3'd7;
        out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 100 && idx < 8; cyc++) begin
            if (out_valid) begin
                total++;
                if (out_data !== exp[63-8*idx -: 8] || out_last !== (idx == 7))
                    $display("FAIL bp word%0d got data=%0h last=%0b want %0h %0b", idx, out_data, out_last, exp[63-8*idx -: 8], idx == 7);
                else passed++;
            end
            out_ready = pattern[3 - (c % 4)];
            c++;
            if (out_ready && out_valid) idx++;
            @(negedge clk);
        end
        total++; if (idx !== 8) $display("FAIL bp count got %0d want 8", idx); else passed++;
        total++;
        if (done !== 1'b1 || busy !== 1'b0) $display("FAIL bp end got done=%0b busy=%0b want 1 0", done, busy);
        else passed++;
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (done !== 1'b0) $display("FAIL bp done-width got %0b want 0", done); else passed++;
    endtask
    task automatic test_busy_reset();
        logic [63:0] exp = 64'hAAF00FCCE718B7ED;
        start_addr = 3'd0;
        last_addr = 3'd7;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[63-8*i -: 8])
                $display("FAIL busy word%0d got valid=%0b data=%0h want 1 %0h", i, out_valid, out_data, exp[63-8*i -: 8]);
            else passed++;
            start = (i == 3);
            start_addr = (i == 3) ? 3'd6 : 3'd0;
            last_addr = (i == 3) ? 3'd6 : 3'd7;
            if (i < 5) @(negedge clk);
        end
        start = 1'b0;
        reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00 || rom_addr !== 3'd0)
            $display("FAIL midreset got valid=%0b busy=%0b last=%0b data=%0h addr=%0h want 0 0 0 0 0", out_valid, busy, out_last, out_data, rom_addr);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL postreset cyc%0d got done=%0b valid=%0b busy=%0b want 0 0 0", i, done, out_valid, busy);
            else passed++;
        end
    endtask
`ifdef ROM_STREAM_LOOP_EN
    task automatic test_loop();
        int dones = 0;
        start_addr = 3'd0;
        last_addr = 3'd1;
        out_ready = 1'b1;
        loop = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== ((i % 2) ? 8'hF0 : 8'hAA) || out_last !== (i % 2 == 1) || done !== (i > 0 && i % 2 == 0))
                $display("FAIL loop word%0d got valid=%0b data=%0h last=%0b done=%0b", i, out_valid, out_data, out_last, done);
            else passed++;
            if (done) dones++;
            if (i == 6) loop = 1'b0;
            @(negedge clk);
        end
        if (done) dones++;
        total++; if (dones !== 4) $display("FAIL loop dones got %0d want 4", dones); else passed++;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL loop end got busy=%0b valid=%0b want 0 0", busy, out_valid);
        else passed++;
    endtask
`endif
    initial begin
        test_reset();
        test_pass("full", 3'd0, 3'd7, 8, 64'hAAF00FCCE718B7ED);
        @(negedge clk);
        test_pass("wrap", 3'd6, 3'd1, 4, 64'hB7EDAAF0_00000000);
        @(negedge clk);
        test_pass("single", 3'd3, 3'd3, 1, 64'hCC000000_00000000);
        test_pass("b2b", 3'd0, 3'd0, 1, 64'hAA000000_00000000);
        @(negedge clk);
        test_backpressure();
        test_busy_reset();
`ifdef ROM_STREAM_LOOP_EN
        test_loop();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
